// File: rtl/alu_rr_arbiter_if.sv
// alu_rr_arbiter_if: requester, ALU and response bundle around the shared-ALU arbiter.
interface alu_rr_arbiter_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int NREQ      = 4
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    logic [NREQ-1:0]           req_valid, req_ready, req_mode, req_cin;
    logic [2*NREQ-1:0]         req_inp_invalid;
    logic [CMD_WIDTH*NREQ-1:0] req_cmd;
    logic [WIDTH*NREQ-1:0]     req_opa, req_opb;
    logic                      alu_ce, alu_mode, alu_cin;
    logic [1:0]                alu_inp_invalid;
    logic [CMD_WIDTH-1:0]      alu_cmd;
    logic [WIDTH-1:0]          alu_opa, alu_opb;
    logic [2*WIDTH:0]          alu_res, rsp_res;
    logic [5:0]                alu_flags, rsp_flags;
    logic                      rsp_valid, rsp_ready;
    logic [IW-1:0]             rsp_id;
    modport master (
        input  req_valid, req_mode, req_cin, req_inp_invalid, req_cmd, req_opa, req_opb,
        input  alu_res, alu_flags, rsp_ready,
        output req_ready, alu_ce, alu_mode, alu_cin, alu_inp_invalid, alu_cmd, alu_opa, alu_opb,
        output rsp_valid, rsp_id, rsp_res, rsp_flags
    );
    modport slave (
        output req_valid, req_mode, req_cin, req_inp_invalid, req_cmd, req_opa, req_opb,
        output alu_res, alu_flags, rsp_ready,
        input  req_ready, alu_ce, alu_mode, alu_cin, alu_inp_invalid, alu_cmd, alu_opa, alu_opb,
        input  rsp_valid, rsp_id, rsp_res, rsp_flags
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one registered ALU, one operation in flight.
// Define ALU_ARB_FIXED_PRIO0_EN to give requester 0 fixed priority over the round-robin.
module alu_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int NREQ      = 4,
    parameter int ALU_LAT   = 1
) (
    input logic clk,
    input logic rst,
    alu_rr_arbiter_if.master bus
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t               state_q, state_d;
    logic [IW-1:0]        rr_q, rr_d, id_q, id_d, win, idx;
    logic [2:0]           cnt_q, cnt_d;
    logic                 any, grant;
    logic [NREQ-1:0]      cand;
    logic                 mode_q, mode_d, cin_q, cin_d;
    logic [1:0]           inv_q, inv_d;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic [2*WIDTH:0]     res_q, res_d;
    logic [5:0]           flags_q, flags_d;

    // Scan downward so the lowest offset from the pointer is the last, winning, hit.
    always_comb begin
        cand = bus.req_valid;
`ifdef ALU_ARB_FIXED_PRIO0_EN
        cand[0] = 1'b0;
`endif
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_q) + k) % NREQ);
            if (cand[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
`ifdef ALU_ARB_FIXED_PRIO0_EN
        if (bus.req_valid[0]) begin
            win = '0;
            any = 1'b1;
        end
`endif
    end

    assign grant = state_q == IDLE && any;
    assign bus.req_ready = (grant && !rst) ? NREQ'(1) << win : '0;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        inv_d   = inv_q;
        cmd_d   = cmd_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: if (grant) begin
                state_d = ISSUE;
                id_d    = win;
                mode_d  = bus.req_mode[win];
                cin_d   = bus.req_cin[win];
                inv_d   = bus.req_inp_invalid[2*int'(win) +: 2];
                cmd_d   = bus.req_cmd[int'(win)*CMD_WIDTH +: CMD_WIDTH];
                opa_d   = bus.req_opa[int'(win)*WIDTH +: WIDTH];
                opb_d   = bus.req_opb[int'(win)*WIDTH +: WIDTH];
                rr_d    = IW'((int'(win) + 1) % NREQ);
`ifdef ALU_ARB_FIXED_PRIO0_EN
                if (win == '0) rr_d = rr_q;
`endif
            end
            ISSUE: begin
                cnt_d   = 3'(ALU_LAT - 1);
                state_d = WAIT;
            end
            WAIT: if (cnt_q == '0) begin
                res_d   = bus.alu_res;
                flags_d = bus.alu_flags;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            inv_q   <= '0;
            cmd_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            inv_q   <= inv_d;
            cmd_q   <= cmd_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign bus.alu_ce          = state_q == ISSUE;
    assign bus.alu_mode        = mode_q;
    assign bus.alu_cin         = cin_q;
    assign bus.alu_inp_invalid = inv_q;
    assign bus.alu_cmd         = cmd_q;
    assign bus.alu_opa         = opa_q;
    assign bus.alu_opb         = opb_q;
    assign bus.rsp_valid       = state_q == RESP;
    assign bus.rsp_id          = id_q;
    assign bus.rsp_res         = res_q;
    assign bus.rsp_flags       = flags_q;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed checks of the shared-ALU arbiter at ALU_LAT 1 and 3.
module tb_alu_rr_arbiter;
    localparam logic [22:0] GARB = {6'h3F, 17'h1ABCD};
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int n;
    logic [22:0] pa;
    logic [22:0] pb [3];

    alu_rr_arbiter_if #(.WIDTH(8), .CMD_WIDTH(4), .NREQ(4)) a ();
    alu_rr_arbiter_if #(.WIDTH(8), .CMD_WIDTH(4), .NREQ(4)) b ();
    alu_rr_arbiter #(.WIDTH(8), .CMD_WIDTH(4), .NREQ(4), .ALU_LAT(1)) u0 (.clk(clk), .rst(rst), .bus(a));
    alu_rr_arbiter #(.WIDTH(8), .CMD_WIDTH(4), .NREQ(4), .ALU_LAT(3)) u1 (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    // Model ALU returns {flags,res}; outside the valid cycle it shows a garbage pattern.
    function automatic logic [22:0] alu_f(input logic m, input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        logic [16:0] r;
        logic err;
        err = !m && c == 4'd15;
        r = err ? 17'h0 : (m && c == 4'd0) ? {8'h0, {1'b0, x} + {1'b0, y}} : {9'h0, x ^ y};
        return {err, 1'b0, !err && x > y, !err && x < y, !err && x == y, r[8], r};
    endfunction

    always @(posedge clk) pa <= a.alu_ce ? alu_f(a.alu_mode, a.alu_cmd, a.alu_opa, a.alu_opb) : GARB;
    always @(posedge clk) begin
        pb[0] <= b.alu_ce ? alu_f(b.alu_mode, b.alu_cmd, b.alu_opa, b.alu_opb) : GARB;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign a.alu_res   = pa[16:0];
    assign a.alu_flags = pa[22:17];
    assign b.alu_res   = pb[2][16:0];
    assign b.alu_flags = pb[2][22:17];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic m, input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        a.req_mode[i]       = m;
        a.req_cmd[4*i +: 4] = c;
        a.req_opa[8*i +: 8] = x;
        a.req_opb[8*i +: 8] = y;
    endtask

    initial begin
        a.req_valid = '0; a.req_mode = '0; a.req_cin = '0; a.req_inp_invalid = '1;
        a.req_cmd = '0; a.req_opa = '0; a.req_opb = '0; a.rsp_ready = 1'b1;
        b.req_valid = '0; b.req_mode = '0; b.req_cin = '0; b.req_inp_invalid = '1;
        b.req_cmd = '0; b.req_opa = '0; b.req_opb = '0; b.rsp_ready = 1'b1;
        tick;
        chk("rst_ready", a.req_ready, 0);
        chk("rst_ce", a.alu_ce, 0);
        chk("rst_valid", a.rsp_valid, 0);
        chk("rst_id", a.rsp_id, 0);
        chk("rst_res", a.rsp_res, 0);
        chk("rst_flags", a.rsp_flags, 0);
        chk("rst_opa", a.alu_opa, 0);
        rst = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'd0, 8'(i + 1), 8'h10);
        a.req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", a.req_ready, 4'b0001 << (k % 4));
            tick;
            if (k == 4) a.req_valid = '0;
            tick;
            tick;
            chk("rr_rsp_valid", a.rsp_valid, 1);
            chk("rr_rsp_id", a.rsp_id, k % 4);
            chk("rr_rsp_res", a.rsp_res, 17'h11 + k % 4);
            chk("rr_rsp_flags", a.rsp_flags, 6'b000100);
            tick;
        end
        set_req(2, 1'b1, 4'd0, 8'h0F, 8'h01);
        a.req_valid = 4'b0100;
        #1;
        chk("single_grant", a.req_ready, 4'b0100);
        tick;
        chk("single_ready_drop", a.req_ready, 0);
        chk("single_ce", a.alu_ce, 1);
        chk("single_opa", a.alu_opa, 8'h0F);
        chk("single_inv", a.alu_inp_invalid, 2'b11);
        a.req_valid = '0;
        tick;
        chk("single_ce_low", a.alu_ce, 0);
        chk("single_opb_hold", a.alu_opb, 8'h01);
        chk("single_wait", a.rsp_valid, 0);
        tick;
        chk("single_valid", a.rsp_valid, 1);
        chk("single_id", a.rsp_id, 2);
        chk("single_res", a.rsp_res, 17'h10);
        chk("single_flags", a.rsp_flags, 6'b001000);
        tick;
        chk("single_done", a.rsp_valid, 0);
        set_req(3, 1'b1, 4'd0, 8'hFF, 8'h01);
        set_req(1, 1'b1, 4'd0, 8'h20, 8'h03);
        a.rsp_ready = 1'b0;
        a.req_valid = 4'b1010;
        #1;
        chk("bp_grant", a.req_ready, 4'b1000);
        tick;
        a.req_valid = 4'b0010;
        tick;
        tick;
        chk("bp_id", a.rsp_id, 3);
        chk("bp_res", a.rsp_res, 17'h100);
        chk("bp_flags", a.rsp_flags, 6'b001001);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_hold_valid", a.rsp_valid, 1);
            chk("bp_hold_res", a.rsp_res, 17'h100);
            chk("bp_hold_ready", a.req_ready, 0);
            chk("bp_hold_ce", a.alu_ce, 0);
        end
        a.rsp_ready = 1'b1;
        tick;
        chk("bp_next_grant", a.req_ready, 4'b0010);
        chk("bp_released", a.rsp_valid, 0);
        tick;
        a.req_valid = '0;
        tick;
        tick;
        chk("bp2_id", a.rsp_id, 1);
        chk("bp2_res", a.rsp_res, 17'h23);
        tick;
        set_req(0, 1'b0, 4'd15, 8'h05, 8'h05);
        a.req_valid = 4'b0001;
        #1;
        chk("err_grant", a.req_ready, 4'b0001);
        tick;
        a.req_valid = '0;
        tick;
        tick;
        chk("err_flag", a.rsp_flags[5], 1);
        chk("err_flags", a.rsp_flags, 6'b100000);
        chk("err_res", a.rsp_res, 0);
        tick;
        a.req_valid = 4'b0100;
        #1;
        chk("rw_grant", a.req_ready, 4'b0100);
        tick;
        a.req_valid = 4'b1010;
        tick;
        chk("rw_in_wait", a.alu_ce, 0);
        rst = 1'b1;
        #1;
        chk("rw_ready", a.req_ready, 0);
        chk("rw_ce", a.alu_ce, 0);
        chk("rw_opa", a.alu_opa, 0);
        chk("rw_mode", a.alu_mode, 0);
        chk("rw_valid", a.rsp_valid, 0);
        chk("rw_id", a.rsp_id, 0);
        chk("rw_res", a.rsp_res, 0);
        tick;
        rst = 1'b0;
        #1;
        chk("rw_fresh_grant", a.req_ready, 4'b0010);
        tick;
        a.req_valid = '0;
        tick;
        tick;
        chk("rw_rsp_id", a.rsp_id, 1);
        chk("rw_rsp_res", a.rsp_res, 17'h23);
        tick;
        set_req(0, 1'b1, 4'd0, 8'h01, 8'h01);
        a.req_valid = 4'b1001;
        #1;
`ifdef ALU_ARB_FIXED_PRIO0_EN
        chk("prio_grant1", a.req_ready, 4'b0001);
`else
        chk("prio_grant1", a.req_ready, 4'b1000);
`endif
        tick;
        tick;
        tick;
`ifdef ALU_ARB_FIXED_PRIO0_EN
        chk("prio_id1", a.rsp_id, 0);
`else
        chk("prio_id1", a.rsp_id, 3);
`endif
        tick;
        chk("prio_grant2", a.req_ready, 4'b0001);
        tick;
        a.req_valid = '0;
        tick;
        tick;
        chk("prio_id2", a.rsp_id, 0);
        chk("prio_res2", a.rsp_res, 17'h2);
        tick;
        b.req_mode[2] = 1'b1;
        b.req_cmd[8 +: 4] = 4'd0;
        b.req_opa[16 +: 8] = 8'h40;
        b.req_opb[16 +: 8] = 8'h02;
        b.req_valid = 4'b0100;
        #1;
        chk("lat_grant", b.req_ready, 4'b0100);
        n = 0;
        do begin
            tick;
            n++;
            if (n == 1) begin
                b.req_valid = '0;
                chk("lat_ce", b.alu_ce, 1);
            end
        end while (!b.rsp_valid && n < 20);
        chk("lat_cycles", n, 5);
        chk("lat_res", b.rsp_res, 17'h42);
        chk("lat_flags", b.rsp_flags, 6'b001000);
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
